// File: rtl/dpram_tdp.sv
// dpram_tdp: true dual-port RAM with per-byte write masks, selectable write
// mode, optional output register, read-valid flags, same-address collision
// resolution with a registered flag and an optional zero-clear sequencer.
// Port A serves fetch/DMA, port B serves the LSU; both run on one clock.
module dpram_tdp #(
    parameter int    RAM_WIDTH  = 32,
    parameter int    RAM_DEPTH  = 2048,
    parameter int    OUT_REG    = 0,
    parameter int    WRITE_MODE = 1,
    parameter int    INIT_CLEAR = 0,
    parameter string INIT_FILE  = "",
    localparam int   BE         = RAM_WIDTH / 8,
    localparam int   AW         = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    // port A
    input  logic                 ena,
    input  logic                 wea,
    input  logic [BE-1:0]        wema,
    input  logic [AW-1:0]        addra,
    input  logic [RAM_WIDTH-1:0] dina,
    output logic [RAM_WIDTH-1:0] douta,
    output logic                 vlda,
    // port B
    input  logic                 enb,
    input  logic                 web,
    input  logic [BE-1:0]        wemb,
    input  logic [AW-1:0]        addrb,
    input  logic [RAM_WIDTH-1:0] dinb,
    output logic [RAM_WIDTH-1:0] doutb,
    output logic                 vldb,
    // status
    output logic                 busy,
    output logic                 coll
);

    // Depth widened by one bit so a non-power-of-2 depth can be compared
    // against any address the AW-bit port can carry.
    localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(RAM_DEPTH);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    logic                 busy_w;
    logic                 clr_we;
    logic [AW-1:0]        clr_addr;

    // ------------------------------------------------------------------
    // Zero-clear sequencer
    // ------------------------------------------------------------------
    if (INIT_CLEAR != 0) begin : g_clear
        typedef enum logic {
            CLR = 1'b0,
            RUN = 1'b1
        } clr_state_e;

        localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

        clr_state_e    state_q, state_d;
        logic [AW-1:0] cnt_q, cnt_d;
        logic          busy_d;
        logic          clr_we_d;

        // State and address counter; reset restarts the clear from word 0.
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= CLR;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Next state: walk every word once, then stay in RUN until reset.
        // NOTE: every output of this block gets a default first, so no
        // path through it can leave a value unassigned and infer a latch.
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            busy_d   = 1'b0;
            clr_we_d = 1'b0;
            case (state_q)
                CLR: begin
                    busy_d   = 1'b1;
                    clr_we_d = ~rst;
                    cnt_d    = cnt_q + AW'(1);
                    if (cnt_q == LAST_ADDR) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
            endcase
            // Busy is also forced while reset is held, before the state
            // register has been initialised.
            if (rst) begin
                busy_d = 1'b1;
            end
        end

        assign busy_w   = busy_d;
        assign clr_we   = clr_we_d;
        assign clr_addr = cnt_q;
    end else begin : g_no_clear
        assign busy_w   = 1'b0;
        assign clr_we   = 1'b0;
        assign clr_addr = '0;
    end

    assign busy = busy_w;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    logic acc_a, acc_b;
    logic inr_a, inr_b;
    logic wr_a, wr_b;
    logic [RAM_WIDTH-1:0] rword_a, rword_b;

    assign acc_a = ena & ~busy_w & ~rst;
    assign acc_b = enb & ~busy_w & ~rst;

    assign inr_a = ({1'b0, addra} < DEPTH_EXT);
    assign inr_b = ({1'b0, addrb} < DEPTH_EXT);

    assign wr_a  = acc_a & wea & inr_a;
    assign wr_b  = acc_b & web & inr_b;

    // Out-of-range words read as zero.
    assign rword_a = inr_a ? mem[addra] : '0;
    assign rword_b = inr_b ? mem[addrb] : '0;

    // ------------------------------------------------------------------
    // Array write: clear sequencer, then port A, then port B per byte,
    // so on a same-address write B's enabled bytes override A's.
    // ------------------------------------------------------------------
    // NOTE: the array deliberately has no reset; clearing it is the job of
    // the sequencer, and a reset here would prevent block-RAM mapping.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end
        for (int i = 0; i < BE; i++) begin
            if (wr_a && wema[i]) begin
                mem[addra][8*i +: 8] <= dina[8*i +: 8];
            end
            if (wr_b && wemb[i]) begin
                mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // First read stage. Reads always return the pre-write word, so a port
    // reading an address the other port is writing sees the old data.
    // ------------------------------------------------------------------
    logic [RAM_WIDTH-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic                 rv_a_q, rv_a_d, rv_b_q, rv_b_d;

    // Port A read-stage next state: reads, and writes in READ_FIRST mode,
    // load the old word and raise valid; everything else holds.
    always_comb begin
        rd_a_d = rd_a_q;
        rv_a_d = 1'b0;
        if (acc_a && (!wea || WRITE_MODE != 0)) begin
            rd_a_d = rword_a;
            rv_a_d = 1'b1;
        end
    end

    // Port B read-stage next state, same rules as port A.
    always_comb begin
        rd_b_d = rd_b_q;
        rv_b_d = 1'b0;
        if (acc_b && (!web || WRITE_MODE != 0)) begin
            rd_b_d = rword_b;
            rv_b_d = 1'b1;
        end
    end

    // Read-stage registers for both ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_a_q <= '0;
            rv_a_q <= 1'b0;
            rd_b_q <= '0;
            rv_b_q <= 1'b0;
        end else begin
            rd_a_q <= rd_a_d;
            rv_a_q <= rv_a_d;
            rd_b_q <= rd_b_d;
            rv_b_q <= rv_b_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional output register. It advances every cycle; because the read
    // stage holds its word when idle, the last result stays on dout.
    // ------------------------------------------------------------------
    if (OUT_REG != 0) begin : g_out_reg
        logic [RAM_WIDTH-1:0] out_a_q, out_b_q;
        logic                 ov_a_q, ov_b_q;

        // Second pipeline stage for data and valid of both ports.
        always_ff @(posedge clk) begin
            if (rst) begin
                out_a_q <= '0;
                ov_a_q  <= 1'b0;
                out_b_q <= '0;
                ov_b_q  <= 1'b0;
            end else begin
                out_a_q <= rd_a_q;
                ov_a_q  <= rv_a_q;
                out_b_q <= rd_b_q;
                ov_b_q  <= rv_b_q;
            end
        end

        assign douta = out_a_q;
        assign vlda  = ov_a_q;
        assign doutb = out_b_q;
        assign vldb  = ov_b_q;
    end else begin : g_no_out_reg
        assign douta = rd_a_q;
        assign vlda  = rv_a_q;
        assign doutb = rd_b_q;
        assign vldb  = rv_b_q;
    end

    // ------------------------------------------------------------------
    // Collision flag: both ports accepted on one address with at least one
    // write. Taken from the first stage so it never depends on OUT_REG.
    // ------------------------------------------------------------------
    logic coll_q, coll_d;

    assign coll_d = acc_a & acc_b & (addra == addrb) & (wea | web);

    // Collision flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign coll = coll_q;

endmodule
